// File: rtl/mc_defs.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes, functs,
// ALU operation codes and datapath mux selects.
package mc_defs;

    typedef enum logic [4:0] {
        StIf  = 5'd0,
        StId  = 5'd1,
        StMa  = 5'd2,
        StMrd = 5'd3,
        StLwb = 5'd4,
        StMwr = 5'd5,
        StRex = 5'd6,
        StRwb = 5'd7,
        StBr  = 5'd8,
        StJ   = 5'd9,
        StIex = 5'd10,
        StIwb = 5'd11,
        StJal = 5'd12,
        StJr  = 5'd13
    } mc_state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;

    localparam logic [5:0] FunJr  = 6'b001000;
    localparam logic [5:0] FunAdd = 6'b100000;
    localparam logic [5:0] FunSub = 6'b100010;
    localparam logic [5:0] FunAnd = 6'b100100;
    localparam logic [5:0] FunOr  = 6'b100101;
    localparam logic [5:0] FunSlt = 6'b101010;
    localparam logic [5:0] FunNor = 6'b100111;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;
    localparam logic [2:0] AluNor = 3'b100;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDst31 = 2'b10;

    localparam logic [1:0] MemtoRegAlu = 2'b00;
    localparam logic [1:0] MemtoRegMdr = 2'b01;
    localparam logic [1:0] MemtoRegPc  = 2'b10;

    localparam logic [1:0] SrcBReg = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm = 2'b10;
    localparam logic [1:0] SrcBBr  = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcRegA   = 2'b11;

    // Logical immediates are zero-extended, arithmetic ones sign-extended.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == OpAndi) || (op == OpOri);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU operation decoder driven by the current control state and the IR fields.
module mc_alu_dec
    import mc_defs::*;
(
    input  mc_state_e  state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] fun_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = AluAnd;
        unique case (state_i)
            StIf, StId, StMa: alu_ctrl_o = AluAdd;
            StBr:             alu_ctrl_o = AluSub;
            StRex: begin
                case (fun_i)
                    FunSub:  alu_ctrl_o = AluSub;
                    FunAnd:  alu_ctrl_o = AluAnd;
                    FunOr:   alu_ctrl_o = AluOr;
                    FunSlt:  alu_ctrl_o = AluSlt;
                    FunNor:  alu_ctrl_o = AluNor;
                    default: alu_ctrl_o = AluAdd;
                endcase
            end
            StIex: begin
                case (op_i)
                    OpSlti:  alu_ctrl_o = AluSlt;
                    OpAndi:  alu_ctrl_o = AluAnd;
                    OpOri:   alu_ctrl_o = AluOr;
                    default: alu_ctrl_o = AluAdd;
                endcase
            end
            default: alu_ctrl_o = AluAnd;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: steps each instruction through fetch/decode/execute/memory/
// writeback and drives every datapath select and write enable.
module mc_ctrl
    import mc_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OP,
    input  logic [5:0] Fun,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       Reg_Wt,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ZeroExt,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       CPU_MIO,
    output logic       IRWrite,
    output logic [2:0] ALU_Control,
    output logic [4:0] state_out
);

    mc_state_e state_q, state_d;
    logic      reg_wt_raw, pc_write_raw, mem_write_raw, ir_write_raw;

    always_comb begin
        state_d = StIf;
        unique case (state_q)
            StIf: state_d = MIO_ready ? StId : StIf;
            StId: begin
                case (OP)
                    OpRtype:                      state_d = (Fun == FunJr) ? StJr : StRex;
                    OpLw, OpSw:                   state_d = StMa;
                    OpBeq, OpBne:                 state_d = StBr;
                    OpJ:                          state_d = StJ;
                    OpJal:                        state_d = StJal;
                    OpAddi, OpSlti, OpAndi, OpOri: state_d = StIex;
                    default:                      state_d = StIf;
                endcase
            end
            StMa:    state_d = (OP == OpSw) ? StMwr : StMrd;
            StMrd:   state_d = MIO_ready ? StLwb : StMrd;
            StMwr:   state_d = MIO_ready ? StIf : StMwr;
            StRex:   state_d = StRwb;
            StIex:   state_d = StIwb;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        reg_wt_raw    = 1'b0;
        RegDst        = RegDstRt;
        MemtoReg      = MemtoRegAlu;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SrcBReg;
        ZeroExt       = 1'b0;
        PCSource      = PcSrcAlu;
        pc_write_raw  = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        unique case (state_q)
            StIf: begin
                MemRead      = 1'b1;
                ALUSrcB      = SrcBFour;
                ir_write_raw = MIO_ready;
                pc_write_raw = MIO_ready;
            end
            StId: ALUSrcB = SrcBBr;
            StMa: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
            end
            StMrd: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            StLwb: begin
                reg_wt_raw = 1'b1;
                MemtoReg   = MemtoRegMdr;
            end
            StMwr: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            StRex: ALUSrcA = 1'b1;
            StRwb: begin
                reg_wt_raw = 1'b1;
                RegDst     = RegDstRd;
            end
            StBr: begin
                ALUSrcA      = 1'b1;
                PCSource     = PcSrcAluOut;
                pc_write_raw = (OP == OpBeq) ? zero : ~zero;
            end
            StJ: begin
                PCSource     = PcSrcJump;
                pc_write_raw = 1'b1;
            end
            StJal: begin
                PCSource     = PcSrcJump;
                pc_write_raw = 1'b1;
                reg_wt_raw   = 1'b1;
                RegDst       = RegDst31;
                MemtoReg     = MemtoRegPc;
            end
            StJr: begin
                PCSource     = PcSrcRegA;
                pc_write_raw = 1'b1;
            end
            StIex: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                ZeroExt = is_zext_op(OP);
            end
            StIwb: begin
                reg_wt_raw = 1'b1;
                ZeroExt    = is_zext_op(OP);
            end
            default: ;
        endcase
    end

    // Write enables are masked by reset so nothing is written while rst is low.
    assign Reg_Wt    = reg_wt_raw & rst;
    assign PCWrite   = pc_write_raw & rst;
    assign MemWrite  = mem_write_raw & rst;
    assign IRWrite   = ir_write_raw & rst;
    assign CPU_MIO   = MemRead | MemWrite;
    assign state_out = state_q;

    mc_alu_dec u_alu_dec (
        .state_i    (state_q),
        .op_i       (OP),
        .fun_i      (Fun),
        .alu_ctrl_o (ALU_Control)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction phase schedule model, random and directed runs.
module tb_mc_ctrl;

    typedef struct packed {
        logic       reg_wt;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       src_a;
        logic [1:0] src_b;
        logic       zext;
        logic [1:0] pc_src;
        logic       pc_wr;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       cpu_mio;
        logic       ir_wr;
        logic [2:0] alu;
        logic [4:0] st;
    } outs_t;

    logic       clk, rst;
    logic [5:0] OP, Fun;
    logic       zero, MIO_ready;
    logic       Reg_Wt, ALUSrcA, ZeroExt, PCWrite, IorD, MemRead, MemWrite, CPU_MIO, IRWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALU_Control;
    logic [4:0] state_out;
    outs_t      act;

    int n_checks = 0;
    int n_err    = 0;
    int seen[$];
    outs_t trace[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .OP(OP), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
        .Reg_Wt(Reg_Wt), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .PCSource(PCSource), .PCWrite(PCWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .IRWrite(IRWrite), .ALU_Control(ALU_Control), .state_out(state_out)
    );

    assign act = {Reg_Wt, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, PCSource, PCWrite,
                  IorD, MemRead, MemWrite, CPU_MIO, IRWrite, ALU_Control, state_out};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic chk_str(input string name, input string a, input string e);
        n_checks++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %s want %s", name, a, e);
        end
    endtask

    function automatic string seq_str();
        string s = "";
        foreach (seen[i]) s = {s, (i == 0) ? "" : ",", $sformatf("%0d", seen[i])};
        return s;
    endfunction

    // Expected outputs for one cycle, straight from the per-phase control table.
    function automatic outs_t exp_outs(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                       input logic z, input logic rdy, input logic rs);
        outs_t o = '0;
        case (ph)
            0:  begin o.mrd = 1; o.src_b = 2'd1; o.alu = 3'b010; o.pc_wr = rdy; o.ir_wr = rdy; end
            1:  begin o.src_b = 2'd3; o.alu = 3'b010; end
            2:  begin o.src_a = 1; o.src_b = 2'd2; o.alu = 3'b010; end
            3:  begin o.iord = 1; o.mrd = 1; end
            4:  begin o.reg_wt = 1; o.mem_to_reg = 2'd1; end
            5:  begin o.iord = 1; o.mwr = 1; end
            6:  begin
                o.src_a = 1;
                case (fn)
                    6'b100010: o.alu = 3'b110;
                    6'b100100: o.alu = 3'b000;
                    6'b100101: o.alu = 3'b001;
                    6'b101010: o.alu = 3'b111;
                    6'b100111: o.alu = 3'b100;
                    default:   o.alu = 3'b010;
                endcase
            end
            7:  begin o.reg_wt = 1; o.reg_dst = 2'd1; end
            8:  begin
                o.src_a = 1; o.alu = 3'b110; o.pc_src = 2'd1;
                o.pc_wr = (op == 6'b000100) ? z : !z;
            end
            9:  begin o.pc_src = 2'd2; o.pc_wr = 1; end
            10: begin
                o.src_a = 1; o.src_b = 2'd2;
                o.zext = (op == 6'b001100) || (op == 6'b001101);
                o.alu = (op == 6'b001010) ? 3'b111 : (op == 6'b001100) ? 3'b000 :
                        (op == 6'b001101) ? 3'b001 : 3'b010;
            end
            11: begin o.reg_wt = 1; o.zext = (op == 6'b001100) || (op == 6'b001101); end
            12: begin
                o.pc_src = 2'd2; o.pc_wr = 1; o.reg_wt = 1; o.reg_dst = 2'd2;
                o.mem_to_reg = 2'd2;
            end
            13: begin o.pc_src = 2'd3; o.pc_wr = 1; end
            default: ;
        endcase
        if (!rs) begin o.pc_wr = 0; o.ir_wr = 0; o.mwr = 0; o.reg_wt = 0; end
        o.cpu_mio = o.mrd | o.mwr;
        o.st = 5'(ph);
        return o;
    endfunction

    // Runs one instruction from IF. rmode 0: always ready, 1: random ready.
    // zmode <0: random zero. stall_mrd: forced not-ready cycles in MRD.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int rmode,
                             input int zmode, input int stall_mrd);
        int sched[$];
        int cycles = 0;
        int mrd_cnt = 0;
        int ph;
        outs_t e;
        seen.delete();
        trace.delete();
        sched = '{0, 1};
        case (op)
            6'b000000: if (fn == 6'b001000) sched.push_back(13);
                       else begin sched.push_back(6); sched.push_back(7); end
            6'b100011: begin sched.push_back(2); sched.push_back(3); sched.push_back(4); end
            6'b101011: begin sched.push_back(2); sched.push_back(5); end
            6'b000100, 6'b000101: sched.push_back(8);
            6'b000010: sched.push_back(9);
            6'b000011: sched.push_back(12);
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                sched.push_back(10); sched.push_back(11);
            end
            default: ;
        endcase
        while (sched.size() > 0 && cycles < 200) begin
            ph = sched[0];
            OP = op;
            Fun = fn;
            zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            MIO_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ph == 3 && mrd_cnt < stall_mrd) begin
                MIO_ready = 1'b0;
                mrd_cnt++;
            end
            #1;
            e = exp_outs(ph, op, fn, zero, MIO_ready, 1'b1);
            chk($sformatf("cycle op=%0h fn=%0h ph=%0d", op, fn, ph), 32'(act), 32'(e));
            seen.push_back(int'(state_out));
            trace.push_back(act);
            cycles++;
            if (!((ph == 0 || ph == 3 || ph == 5) && !MIO_ready)) void'(sched.pop_front());
            @(negedge clk);
        end
        if (cycles >= 200) chk("cycle_budget", 32'(cycles), 32'd0);
    endtask

    initial begin
        logic [5:0] ops[12];
        logic [5:0] funs[8];
        int n_wt;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                6'h3f};
        funs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h08, 6'h11};

        rst = 1'b0; OP = '0; Fun = '0; zero = 1'b0; MIO_ready = 1'b1;
        #2;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pcwrite", 32'(PCWrite), 32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd1);
        chk("rst_alusrcb", 32'(ALUSrcB), 32'd1);
        chk("rst_alu", 32'(ALU_Control), 32'b010);
        #5;
        chk("rst_hold_state", 32'(state_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_instr(6'h00, 6'h20, 0, 0, 0);
        chk_str("radd_seq", seq_str(), "0,1,6,7");
        chk("radd_alu", 32'(trace[2].alu), 32'b010);
        chk("radd_rwb_wt", 32'({trace[3].reg_wt, trace[3].reg_dst}), 32'b101);
        n_wt = 0;
        foreach (trace[i]) n_wt += int'(trace[i].reg_wt);
        chk("radd_wt_count", 32'(n_wt), 32'd1);

        run_instr(6'h23, 6'h00, 0, 0, 2);
        chk_str("lw_seq", seq_str(), "0,1,2,3,3,3,4");
        chk("lw_iord", 32'({trace[3].iord, trace[4].iord, trace[5].iord}), 32'b111);
        chk("lw_lwb", 32'({trace[6].mem_to_reg, trace[6].reg_wt}), 32'b011);

        run_instr(6'h04, 6'h00, 0, 1, 0);
        chk("beq_z1", 32'({trace[2].pc_wr, trace[2].pc_src}), 32'b101);
        run_instr(6'h04, 6'h00, 0, 0, 0);
        chk("beq_z0", 32'(trace[2].pc_wr), 32'd0);
        run_instr(6'h05, 6'h00, 0, 1, 0);
        chk("bne_z1", 32'(trace[2].pc_wr), 32'd0);
        run_instr(6'h05, 6'h00, 0, 0, 0);
        chk("bne_z0", 32'(trace[2].pc_wr), 32'd1);

        run_instr(6'h03, 6'h00, 0, 0, 0);
        chk_str("jal_seq", seq_str(), "0,1,12");
        chk("jal_ctl", 32'({trace[2].pc_wr, trace[2].reg_wt, trace[2].reg_dst,
                            trace[2].mem_to_reg, trace[2].pc_src}), 32'b11101010);

        run_instr(6'h0d, 6'h00, 0, 0, 0);
        chk("ori_iex", 32'({trace[2].zext, trace[2].alu}), 32'b1001);
        chk("ori_cycles", 32'(seen.size()), 32'd4);

        run_instr(6'h3f, 6'h00, 0, 0, 0);
        chk_str("nop_seq", seq_str(), "0,1");
        chk("nop_nowrite", 32'({trace[1].reg_wt, trace[1].pc_wr, trace[1].mwr,
                                trace[1].ir_wr}), 32'd0);

        run_instr(6'h02, 6'h00, 0, 0, 0);
        chk("j_cycles", 32'(seen.size()), 32'd3);
        run_instr(6'h00, 6'h08, 0, 0, 0);
        chk("jr_cycles", 32'(seen.size()), 32'd3);
        run_instr(6'h2b, 6'h00, 0, 0, 0);
        chk("sw_cycles", 32'(seen.size()), 32'd4);

        // Abort a store mid-wait with an asynchronous reset.
        OP = 6'h2b; Fun = '0; zero = 1'b0; MIO_ready = 1'b1;
        repeat (3) @(negedge clk);
        MIO_ready = 1'b0;
        #1;
        chk("mwr_state", 32'(state_out), 32'd5);
        chk("mwr_memwrite", 32'(MemWrite), 32'd1);
        #2;
        rst = 1'b0;
        MIO_ready = 1'b1;
        #1;
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_outs", 32'(act), 32'(exp_outs(0, OP, Fun, zero, MIO_ready, 1'b0)));
        @(negedge clk);
        chk("arst_hold", 32'(act), 32'(exp_outs(0, OP, Fun, zero, MIO_ready, 1'b0)));
        rst = 1'b1;
        run_instr(6'h08, 6'h00, 0, 0, 0);
        chk_str("resume_seq", seq_str(), "0,1,10,11");

        for (int k = 0; k < 300; k++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 11)];
            fn = funs[$urandom_range(0, 7)];
            if (op == 6'h3f) op = 6'($urandom);
            run_instr(op, fn, 1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the single-issue MIPS datapath. It decodes `OP`/`Fun` from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable, including `Reg_Wt`, which feeds the register file's write-enable (`L_S`) directly. It waits on a memory ready handshake during every memory access.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- `clk`  in  1  system clock; all state changes occur on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `OP`  in  6  instruction[31:26], taken from the IR.
- `Fun`  in  6  instruction[5:0], taken from the IR.
- `zero`  in  1  ALU zero flag.
- `MIO_ready`  in  1  memory has completed the current access.
- `Reg_Wt`  out  1  register-file write enable.
- `RegDst`  out  2  write-address select: 00=rt, 01=rd, 10=31.
- `MemtoReg`  out  2  write-data select: 00=ALUOut, 01=MDR, 10=PC.
- `ALUSrcA`  out  1  ALU A input: 0=PC, 1=regA.
- `ALUSrcB`  out  2  ALU B input: 00=regB, 01=4, 10=ext(imm), 11=sext(imm)<<2.
- `ZeroExt`  out  1  immediate extension: 1=zero-extend, 0=sign-extend.
- `PCSource`  out  2  next-PC select: 00=ALU, 01=ALUOut, 10=jump target, 11=regA.
- `PCWrite`  out  1  final PC enable; conditional branches are already resolved inside this block.
- `IorD`  out  1  memory address select: 0=PC, 1=ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `CPU_MIO`  out  1  memory transaction active; equals MemRead|MemWrite.
- `IRWrite`  out  1  instruction register load enable.
- `ALU_Control`  out  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor.
- `state_out`  out  5  current state, for debug display.

## Operation
- Outputs are Moore-decoded from the state. The only exceptions are `IRWrite`/`PCWrite` in IF, which are additionally qualified by `MIO_ready`, and the branch condition in BR.
- State encodings:
  - IF=0, ID=1, MA=2, MRD=3, LWB=4, MWR=5, REX=6, RWB=7
  - BR=8, J=9, IEX=10, IWB=11, JAL=12, JR=13
- IF: `MemRead`, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSource`=00.
  - `MIO_ready`=1: `IRWrite`=1, `PCWrite`=1, go to ID.
  - `MIO_ready`=0: hold in IF.
- ID: `ALUSrcA`=0, `ALUSrcB`=11, add (computes branch target). Dispatch on `OP`:
  - 000000: `Fun`=001000 → JR, else REX.
  - 100011 (lw) or 101011 (sw) → MA.
  - 000100 (beq) or 000101 (bne) → BR.
  - 000010 (j) → J; 000011 (jal) → JAL.
  - 001000 (addi), 001010 (slti), 001100 (andi), 001101 (ori) → IEX.
  - Any other opcode → IF (executes as a NOP).
- MA: `ALUSrcA`=1, `ALUSrcB`=10, `ZeroExt`=0, add. Goes to MRD for lw, MWR for sw.
- MRD: `IorD`=1, `MemRead`. Holds until `MIO_ready`, then LWB.
- LWB: `Reg_Wt`, `RegDst`=00, `MemtoReg`=01, then IF.
- MWR: `IorD`=1, `MemWrite`. Holds until `MIO_ready`, then IF.
- REX: `ALUSrcA`=1, `ALUSrcB`=00. ALU op from `Fun`:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor.
  - Any other `Fun` gives add.
  - Then RWB.
- RWB: `Reg_Wt`, `RegDst`=01, `MemtoReg`=00, then IF.
- BR: `ALUSrcA`=1, `ALUSrcB`=00, sub, `PCSource`=01.
  - `PCWrite` = beq ? `zero` : ~`zero`.
  - Then IF.
- J: `PCSource`=10, `PCWrite`, then IF.
- JAL: `PCSource`=10, `PCWrite`, `Reg_Wt`, `RegDst`=10, `MemtoReg`=10. The PC already holds PC+4 at this point. Then IF.
- JR: `PCSource`=11, `PCWrite`, then IF.
- IEX: `ALUSrcA`=1, `ALUSrcB`=10.
  - `ZeroExt`=1 for andi/ori, 0 for addi/slti.
  - ALU op: addi→add, slti→slt, andi→and, ori→or.
  - Then IWB.
- IWB: `Reg_Wt`, `RegDst`=00, `MemtoReg`=00, `ZeroExt` held as in IEX, then IF.
- Write enables not listed for a state are 0. Select outputs not listed for a state are 0.

## Timing
- Reset (`rst`=0): state=IF immediately, asynchronously.
  - `PCWrite`, `IRWrite`, `MemWrite`, `Reg_Wt` are forced to 0 while `rst`=0.
  - All other outputs carry the IF decode.
  - `state_out`=0.
- Reset asserted mid-instruction aborts it. No write enable is asserted after `rst` falls.
- Cycle counts with zero wait states:
  - 3 cycles: beq/bne, j, jal, jr.
  - 4 cycles: R-type, I-type, sw.
  - 5 cycles: lw.
- Each cycle with `MIO_ready`=0 in IF, MRD or MWR adds one cycle. `MemRead`/`MemWrite`/`IorD` stay stable throughout the wait.
- `Reg_Wt` is high for exactly one cycle per register-writing instruction. That cycle is the final cycle before IF.

## Structure
- Package `mc_defs`: state encodings, opcode and funct constants, `ALU_Control` codes, and mux-select codes.
- Sub-module `mc_alu_dec`: combinational `OP`/`Fun`/state → `ALU_Control` decoder. The FSM itself lives in `mc_ctrl`.

## Test plan
- Reset then `MIO_ready`=1, `OP`=000000, `Fun`=100000:
  - States 0→1→6→7→0.
  - `ALU_Control`=010 in REX.
  - `Reg_Wt`=1 with `RegDst`=01 only in RWB.
- lw (`OP`=100011) with `MIO_ready` low for 2 cycles in MRD:
  - Sequence 0,1,2,3,3,3,4.
  - `IorD`=1 held throughout MRD.
  - LWB shows `MemtoReg`=01, `Reg_Wt`=1.
- beq: `zero`=1 → `PCWrite`=1, `PCSource`=01 in BR. Repeat with `zero`=0 → `PCWrite`=0. bne gives the inverse result in both cases.
- jal: three cycles. JAL state shows `PCWrite`=1, `Reg_Wt`=1, `RegDst`=10, `MemtoReg`=10, `PCSource`=10.
- ori (`OP`=001101): IEX shows `ZeroExt`=1, `ALU_Control`=001. Unknown opcode 111111: ID goes directly to IF with no writes.
- `rst` pulled low during MWR with `MemWrite`=1:
  - `MemWrite` drops and state=0 immediately, without waiting for a clock edge.
  - After release, fetch resumes.
